// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard: decode-stage stall and per-operand forward distance.
// Optional SCOREBOARD_STATS_EN adds saturating stall_cnt / full_cnt counters.
module hazard_scoreboard #(
   parameter int AW      = 5,
   parameter int DEPTH   = 4,
   parameter int LATW    = 3,
   parameter int WB_DIST = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic                         flush,
   input  logic [AW-1:0]                issue_rs,
   input  logic                         issue_rs_used,
   input  logic [AW-1:0]                issue_rt,
   input  logic                         issue_rt_used,
   input  logic [AW-1:0]                issue_rd,
   input  logic                         issue_rd_we,
   input  logic [LATW-1:0]              issue_lat,
   output logic                         stall,
   output logic                         full,
   output logic [LATW-1:0]              fwd_a,
   output logic [LATW-1:0]              fwd_b,
   output logic [$clog2(DEPTH+1)-1:0]   inflight
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [15:0]                  stall_cnt,
   output logic [15:0]                  full_cnt
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [LATW-1:0] WB_AGE  = LATW'(WB_DIST);
   localparam logic [LATW-1:0] LAT_ONE = LATW'(1);

   logic [DEPTH-1:0] valid_reg;
   logic [AW-1:0]    rd_reg  [DEPTH];
   logic [LATW-1:0]  lat_reg [DEPTH];
   logic [LATW-1:0]  age_reg [DEPTH];
   logic [CW-1:0]    inflight_reg;

   logic [DEPTH-1:0] retiring, busy, match_a, match_b, free_slot, alloc_sel, valid_next;
   logic [CW-1:0]    count_next;
   logic [LATW-1:0]  age_a, age_b, lat_a, lat_b, lat_eff;
   logic             hit_a, hit_b, hazard_a, hazard_b, wr_real, alloc;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign retiring[gi] = valid_reg[gi] && (age_reg[gi] == WB_AGE);
         assign busy[gi]     = valid_reg[gi] && !retiring[gi];
         assign match_a[gi]  = issue_rs_used && (issue_rs != '0) && valid_reg[gi] &&
                               (rd_reg[gi] == issue_rs);
         assign match_b[gi]  = issue_rt_used && (issue_rt != '0) && valid_reg[gi] &&
                               (rd_reg[gi] == issue_rt);
         assign valid_next[gi] = busy[gi] || (alloc && alloc_sel[gi]);
      end
   endgenerate

   // Youngest match wins; ages of valid entries are unique since at most one issues per cycle.
   always_comb begin
      hit_a = 1'b0;
      age_a = '0;
      lat_a = '0;
      hit_b = 1'b0;
      age_b = '0;
      lat_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match_a[i] && (!hit_a || (age_reg[i] < age_a))) begin
            hit_a = 1'b1;
            age_a = age_reg[i];
            lat_a = lat_reg[i];
         end
         if (match_b[i] && (!hit_b || (age_reg[i] < age_b))) begin
            hit_b = 1'b1;
            age_b = age_reg[i];
            lat_b = lat_reg[i];
         end
      end
   end

   assign hazard_a = hit_a && (age_a < lat_a);
   assign hazard_b = hit_b && (age_b < lat_b);
   assign wr_real  = issue_rd_we && (issue_rd != '0);
   assign full     = wr_real && (&busy);
   assign stall    = issue_valid && !flush && (hazard_a || hazard_b || full);
   assign alloc    = issue_valid && !flush && !stall && wr_real;
   assign fwd_a    = age_a;
   assign fwd_b    = age_b;
   assign inflight = inflight_reg;

   // Lowest-index free slot as a one-hot; a slot retiring this edge is already free.
   assign free_slot = ~busy;
   assign alloc_sel = free_slot & (~free_slot + DEPTH'(1));

   assign lat_eff = (issue_lat == '0)    ? LAT_ONE :
                    (issue_lat > WB_AGE) ? WB_AGE  : issue_lat;

   always_comb begin
      count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + CW'(valid_next[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg    <= '0;
         inflight_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            age_reg[i] <= '0;
         end
      end else begin
         valid_reg    <= valid_next;
         inflight_reg <= count_next;
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc && alloc_sel[i]) begin
               age_reg[i] <= LAT_ONE;
            end else if (retiring[i]) begin
               age_reg[i] <= '0;
            end else if (valid_reg[i]) begin
               age_reg[i] <= age_reg[i] + LAT_ONE;
            end
         end
      end
   end

   // Payload fields are only meaningful while valid, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc && alloc_sel[i]) begin
            rd_reg[i]  <= issue_rd;
            lat_reg[i] <= lat_eff;
         end
      end
   end

`ifdef SCOREBOARD_STATS_EN
   logic [15:0] stall_cnt_reg, full_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_reg <= '0;
         full_cnt_reg  <= '0;
      end else begin
         if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         end
         if (stall && full && (full_cnt_reg != 16'hFFFF)) begin
            full_cnt_reg <= full_cnt_reg + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign full_cnt  = full_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed steps plus random traffic against a queue-based model of in-flight writes.
module tb_hazard_scoreboard;

   localparam int WB = 3;
   localparam int DP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid, flush, rs_used, rt_used, rd_we;
   logic [4:0] rs, rt, rd;
   logic [2:0] lat;

   logic       stall, full, stall2, full2;
   logic [2:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
   logic [2:0] inflight;
   logic [1:0] inflight2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit acc    = 1'b0;

   typedef struct {
      int rd;
      int lat;
      int t;
   } wr_t;
   wr_t q[$];

   always #5 clk = ~clk;

   hazard_scoreboard #(.AW(5), .DEPTH(DP), .LATW(3), .WB_DIST(WB)) u_dut (
      .clk(clk), .reset(rst), .issue_valid(valid), .flush(flush),
      .issue_rs(rs), .issue_rs_used(rs_used), .issue_rt(rt), .issue_rt_used(rt_used),
      .issue_rd(rd), .issue_rd_we(rd_we), .issue_lat(lat),
      .stall(stall), .full(full), .fwd_a(fwd_a), .fwd_b(fwd_b), .inflight(inflight)
   );

   hazard_scoreboard #(.AW(5), .DEPTH(2), .LATW(3), .WB_DIST(WB)) u_dut2 (
      .clk(clk), .reset(rst), .issue_valid(valid), .flush(flush),
      .issue_rs(rs), .issue_rs_used(rs_used), .issue_rt(rt), .issue_rt_used(rt_used),
      .issue_rd(rd), .issue_rd_we(rd_we), .issue_lat(lat),
      .stall(stall2), .full(full2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .inflight(inflight2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      checks++;
      assert (obs === 32'(expv)) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_in(input bit v, input bit fl, input int a, input bit au,
                         input int b, input bit bu, input int d, input bit dw, input int l);
      valid   = v;
      flush   = fl;
      rs      = 5'(a);
      rs_used = au;
      rt      = 5'(b);
      rt_used = bu;
      rd      = 5'(d);
      rd_we   = dw;
      lat     = 3'(l);
   endtask

   // Reference: every accepted write lives for WB cycles; age is simply cycles since issue.
   task automatic settle();
      int  best_a, best_b, lat_a, lat_b, live, age;
      bit  hz_a, hz_b, fl, e_stall;
      #1;
      best_a = -1; best_b = -1; lat_a = 0; lat_b = 0; live = 0;
      foreach (q[i]) begin
         age = cyc - q[i].t;
         if (age < WB) live++;
         if (rs_used && rs != 0 && q[i].rd == int'(rs) && (best_a < 0 || age < best_a)) begin
            best_a = age;
            lat_a  = q[i].lat;
         end
         if (rt_used && rt != 0 && q[i].rd == int'(rt) && (best_b < 0 || age < best_b)) begin
            best_b = age;
            lat_b  = q[i].lat;
         end
      end
      hz_a    = (best_a >= 0) && (best_a < lat_a);
      hz_b    = (best_b >= 0) && (best_b < lat_b);
      fl      = rd_we && (rd != 0) && (live == DP);
      e_stall = valid && !flush && (hz_a || hz_b || fl);
      acc     = valid && !flush && !e_stall && rd_we && (rd != 0);
      chk("stall", 32'(stall), int'(e_stall));
      chk("full", 32'(full), int'(fl));
      chk("inflight", 32'(inflight), q.size());
      if (!e_stall) begin
         chk("fwd_a", 32'(fwd_a), (best_a < 0) ? 0 : best_a);
         chk("fwd_b", 32'(fwd_b), (best_b < 0) ? 0 : best_b);
      end
   endtask

   task automatic tick();
      wr_t w;
      int  l;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else if (acc) begin
         l    = int'(lat);
         w.rd  = int'(rd);
         w.lat = (l == 0) ? 1 : ((l > WB) ? WB : l);
         w.t   = cyc;
         q.push_back(w);
      end
      cyc++;
      while (q.size() > 0 && (cyc - q[0].t) > WB) void'(q.pop_front());
      acc = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         settle();
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_in(i[0], 0, 3, 1, 5, 1, 3, 1, 1);
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      do_reset();

      // Reset state
      set_in(1, 0, 3, 1, 5, 1, 6, 1, 1);
      #1;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_fwd_a", 32'(fwd_a), 0);
      chk("rst_fwd_b", 32'(fwd_b), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_inflight2", 32'(inflight2), 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      settle();
      tick();
      drain();

      // ALU forwarding
      set_in(1, 0, 0, 0, 0, 0, 3, 1, 1);
      settle(); tick();
      for (int k = 1; k <= 4; k++) begin
         set_in(1, 0, 3, 1, 0, 0, 0, 0, 1);
         settle();
         chk($sformatf("alu_stall_c%0d", k), 32'(stall), 0);
         chk($sformatf("alu_fwd_a_c%0d", k), 32'(fwd_a), (k == 4) ? 0 : k);
         tick();
      end
      chk("alu_inflight_end", 32'(inflight), 0);

      // Load-use
      set_in(1, 0, 0, 0, 0, 0, 5, 1, 2);
      settle(); tick();
      set_in(1, 0, 0, 0, 5, 1, 0, 0, 1);
      settle();
      chk("lu_stall", 32'(stall), 1);
      tick();
      settle();
      chk("lu_stall_after", 32'(stall), 0);
      chk("lu_fwd_b", 32'(fwd_b), 2);
      tick();
      drain();

      // Youngest wins
      set_in(1, 0, 0, 0, 0, 0, 7, 1, 1);
      settle(); tick();
      settle(); tick();
      set_in(1, 0, 7, 1, 0, 0, 0, 0, 1);
      settle();
      chk("young_fwd_a", 32'(fwd_a), 1);
      tick();
      drain();

      // Zero register and flush
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 1);
      settle(); tick();
      chk("r0_inflight", 32'(inflight), 0);
      set_in(1, 0, 0, 0, 0, 0, 4, 1, 2);
      settle(); tick();
      set_in(1, 1, 4, 1, 0, 0, 6, 1, 1);
      settle();
      chk("flush_stall", 32'(stall), 0);
      tick();
      chk("flush_inflight", 32'(inflight), 1);
      drain();

      // Latency clamps: 0 behaves as 1, 7 behaves as WB
      set_in(1, 0, 0, 0, 0, 0, 9, 1, 0);
      settle(); tick();
      set_in(1, 0, 9, 1, 0, 0, 0, 0, 1);
      settle();
      chk("lat0_stall", 32'(stall), 0);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 10, 1, 7);
      settle(); tick();
      set_in(1, 0, 0, 0, 10, 1, 0, 0, 1);
      for (int k = 1; k <= 3; k++) begin
         settle();
         chk($sformatf("latmax_stall_age%0d", k), 32'(stall), (k < 3) ? 1 : 0);
         tick();
      end
      drain();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         set_in(($urandom % 4) != 0, ($urandom % 8) == 0,
                int'($urandom_range(0, 7)), $urandom % 2,
                int'($urandom_range(0, 7)), $urandom % 2,
                int'($urandom_range(0, 7)), ($urandom % 3) != 0,
                int'($urandom_range(0, 7)));
         settle();
         tick();
      end

      // Reset in the middle of traffic discards everything
      set_in(1, 0, 0, 0, 0, 0, 2, 1, 3);
      settle(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_in(1, 0, 2, 1, 0, 0, 0, 0, 1);
      settle();
      chk("midrst_inflight", 32'(inflight), 0);
      chk("midrst_stall", 32'(stall), 0);
      tick();

      // Full on the two-entry instance
      do_reset();
      set_in(1, 0, 0, 0, 0, 0, 1, 1, 1);
      settle(); tick();
      set_in(1, 0, 0, 0, 0, 0, 2, 1, 1);
      settle(); tick();
      set_in(1, 0, 0, 0, 0, 0, 3, 1, 1);
      settle();
      chk("full2_full_c2", 32'(full2), 1);
      chk("full2_stall_c2", 32'(stall2), 1);
      chk("full2_inflight_c2", 32'(inflight2), 2);
      tick();
      settle();
      chk("full2_full_c3", 32'(full2), 0);
      chk("full2_stall_c3", 32'(stall2), 0);
      tick();
      set_in(1, 0, 3, 1, 2, 1, 0, 0, 1);
      settle();
      chk("full2_inflight_c4", 32'(inflight2), 2);
      chk("full2_fwd_a_c4", 32'(fwd_a2), 1);
      chk("full2_fwd_b_c4", 32'(fwd_b2), 3);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-wiring forwarding and hazard units of the 5-stage MIPS core.
- Tracks every in-flight register write in a small table. Each entry holds destination, result latency and age.
- From the table it produces the decode-stage stall and the per-operand forward-distance selects.
- Generalises register count, in-flight depth, pipeline distance to writeback and per-instruction result latency (ALU = 1, load = 2, future multi-cycle ops > 2).

Parameters:
- AW, 5: register address width (2^AW architectural registers; register 0 is never tracked).
- DEPTH, 4: in-flight table entries.
- LATW, 3: width of the latency, age and forward-select fields.
- WB_DIST, 3: age at which an entry's result is written to the regfile and the entry retires. Must satisfy 1 <= WB_DIST <= 2^LATW-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode-stage instruction presented this cycle
- flush  in  1  squash the decode-stage instruction this cycle
- issue_rs  in  AW  source A register
- issue_rs_used  in  1  source A is read
- issue_rt  in  AW  source B register
- issue_rt_used  in  1  source B is read
- issue_rd  in  AW  destination register
- issue_rd_we  in  1  instruction writes issue_rd
- issue_lat  in  LATW  cycles after issue until the result is forwardable (1..WB_DIST)
- stall  out  1  hold PC and IF/ID, inject bubble
- full  out  1  no free entry for a writing instruction
- fwd_a  out  LATW  source A forward distance (0 = regfile, k = result from the instruction issued k cycles ago)
- fwd_b  out  LATW  source B forward distance, same encoding
- inflight  out  clog2(DEPTH+1)  number of valid entries

Behaviour:
- Entry fields: valid, rd[AW], lat[LATW], age[LATW].
- Reset (synchronous, active-high): all valid = 0 and all age = 0. This gives stall=0, full=0, fwd_a=fwd_b=0, inflight=0. Reset mid-operation discards all entries in the same edge.
- Aging, every cycle regardless of stall: each valid entry's age increments by 1. An entry with age == WB_DIST clears valid at that edge (retire).
- Match for source A: issue_rs_used, issue_rs != 0, entry valid, entry.rd == issue_rs. Source B is the same test with issue_rt.
- With multiple matches, the youngest entry (smallest age) wins. Older matches are ignored.
- Data hazard: winning entry has age < lat.
- Full: issue_rd_we && issue_rd != 0 && every entry is valid and not retiring this cycle.
- stall = issue_valid && !flush && (hazard on A || hazard on B || full). The outputs stall and full are combinational from table state plus issue inputs.
- fwd_a and fwd_b are combinational. Each equals the winning entry's age, or 0 if there is no match. Values are defined only when stall=0.
- Allocation: occurs on the edge when issue_valid && !flush && !stall && issue_rd_we && issue_rd != 0.
  - Lowest-index free slot is used. A slot retiring on the same edge counts as free.
  - The new entry gets rd=issue_rd, lat=issue_lat, age=1, valid=1.
- issue_rd == 0 never allocates and never stalls on full.
- flush suppresses allocation and forces stall=0. Existing entries keep aging.
- issue_lat == 0 is treated as 1. issue_lat > WB_DIST is treated as WB_DIST.
- Data forwarded from age == WB_DIST (writeback stage) is selected in the same cycle the regfile is written, so regfile write-through is not required.
- inflight is the count of valid entries after the edge (registered).

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt, out, 16 bits: counts cycles with stall=1 and saturates at 16'hFFFF.
  - full_cnt, out, 16 bits: counts cycles with full=1 and stall=1, also saturating.
  - Both clear on reset.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset: assert reset 2 cycles with issue_valid=1 toggling -> stall=0, full=0, fwd_a=fwd_b=0, inflight=0 on the first edge after reset.
- ALU forwarding: issue add rd=3 lat=1 at cycle 0, then a reader rs=3 at cycles 1, 2, 3, 4 -> stall=0 throughout; fwd_a = 1, 2, 3, 0; inflight returns to 0 after cycle 3.
- Load-use: issue lw rd=5 lat=2, then reader rt=5 next cycle -> stall=1 for 1 cycle; the next cycle gives stall=0 and fwd_b=2.
- Youngest wins: writers rd=7 at cycles 0 and 1, reader rs=7 at cycle 2 -> fwd_a=1, not 2.
- Zero register / flush: writer with rd=0 -> inflight unchanged. Load rd=4 followed by reader rs=4 with flush=1 -> stall=0 and no allocation.
- Full, with DEPTH=2 and WB_DIST=3: three back-to-back writers rd=1, 2, 3 at lat=1 -> third gets full=1 and stall=1 at cycle 2. It is accepted at cycle 3 into the slot retired by rd=1 (slot 0), and inflight stays 2.
